row_unpacker: RTL and testbench

ROW_UNPACKER -- requirements
Module: row_unpacker

---
 rtl/row_unpacker.sv | 110 +++++++++++
 tb/tb_row_unpacker.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/row_unpacker.sv
// Purpose : left-aligned byte buffer that packs 64-byte beats and hands out fields of 1..64 bytes, MSB first.
// Latency : an extracted field appears in the output register one cycle after req_ready; beats land in one cycle.
// Backpressure: in_ready drops above 64 buffered bytes; req_ready waits for enough bytes and a free output register.
//
// Ports:
//   clock, resetn             rising-edge clock, synchronous active-low reset
//   in_valid/in_data/in_ready packed 64-byte input beats (stream byte 0 in the top byte)
//   req_valid/req_size/req_ready  field extraction requests, size in bytes (1..64 legal)
//   out_valid/out_data/out_size/out_ready  extracted field, left-aligned, low bytes zero
//   flush                     drop all buffered bytes (output register untouched)
//   avail_bytes               buffered byte count, 0..128
//   size_err                  sticky flag for a request with size 0 or above 64
module row_unpacker #(
   parameter int DATA_WIDTH = 512
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   input  logic                  req_valid,
   input  logic [6:0]            req_size,
   output logic                  req_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [6:0]            out_size,
   input  logic                  out_ready,
   input  logic                  flush,
   output logic [7:0]            avail_bytes,
   output logic                  size_err
);

   localparam int BUF_W = 2 * DATA_WIDTH;

   logic [BUF_W-1:0]      buf_q;
   logic [BUF_W-1:0]      buf_shifted;
   logic [BUF_W-1:0]      buf_ins;
   logic [7:0]            avail_d;
   logic                  req_legal;
   logic                  fire;
   logic                  bad_req;
   logic                  accept;
   logic [7:0]            taken;
   logic [7:0]            offset;
   logic [9:0]            take_bits;
   logic [10:0]           ins_bits;
   logic [DATA_WIDTH-1:0] field_mask;
   logic [DATA_WIDTH-1:0] field;

   assign req_legal = (req_size != 7'd0) && (req_size <= 7'd64);

   // An extraction needs the whole field already buffered and a free (or draining) output register.
   assign fire = !flush && req_valid && req_legal
              && (avail_bytes >= {1'b0, req_size})
              && (!out_valid || out_ready);

   // Illegal sizes are consumed immediately so they never stall the request stream.
   assign bad_req   = !flush && req_valid && !req_legal;
   assign req_ready = fire || bad_req;

   // At most 64 bytes buffered before a beat means the 128-byte buffer can never overflow.
   assign in_ready = !flush && (avail_bytes <= 8'd64);
   assign accept   = in_valid && in_ready;

   assign taken     = fire ? {1'b0, req_size} : 8'd0;
   assign offset    = avail_bytes - taken;
   assign take_bits = {req_size, 3'b000};
   assign ins_bits  = {offset, 3'b000};

   // Keep the top req_size bytes of the buffer; a shift by the full width yields an all-ones mask.
   assign field_mask = ~({DATA_WIDTH{1'b1}} >> take_bits);
   assign field      = buf_q[BUF_W-1 -: DATA_WIDTH] & field_mask;

   // The new beat is placed just behind the bytes that survive this cycle's extraction.
   assign buf_shifted = fire   ? (buf_q << take_bits) : buf_q;
   assign buf_ins     = accept ? ({in_data, {DATA_WIDTH{1'b0}}} >> ins_bits) : '0;
   assign avail_d     = avail_bytes - taken + (accept ? 8'd64 : 8'd0);

   always_ff @(posedge clock) begin
      if (!resetn) begin
         buf_q       <= '0;
         avail_bytes <= 8'd0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_size    <= 7'd0;
         size_err    <= 1'b0;
      end else begin
         if (flush) begin
            buf_q       <= '0;
            avail_bytes <= 8'd0;
         end else begin
            buf_q       <= buf_shifted | buf_ins;
            avail_bytes <= avail_d;
         end

         if (fire) begin
            out_valid <= 1'b1;
            out_data  <= field;
            out_size  <= req_size;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         if (bad_req) begin
            size_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_row_unpacker.sv
module tb_row_unpacker;

   logic         clock;
   logic         resetn;
   logic         in_valid;
   logic [511:0] in_data;
   logic         in_ready;
   logic         req_valid;
   logic [6:0]   req_size;
   logic         req_ready;
   logic         out_valid;
   logic [511:0] out_data;
   logic [6:0]   out_size;
   logic         out_ready;
   logic         flush;
   logic [7:0]   avail_bytes;
   logic         size_err;

   int n_tests = 0;
   int n_fail  = 0;

   row_unpacker #(.DATA_WIDTH(512)) dut (
      .clock       (clock),
      .resetn      (resetn),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .req_valid   (req_valid),
      .req_size    (req_size),
      .req_ready   (req_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_size    (out_size),
      .out_ready   (out_ready),
      .flush       (flush),
      .avail_bytes (avail_bytes),
      .size_err    (size_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic       fl;
      logic       iv;
      int         ib;     // first byte value of the offered beat
      logic       rv;
      logic [6:0] rs;
      logic       ordy;
      logic       e_inr;
      logic       e_rqr;
      int         e_av;
      logic       e_ov;
      int         e_fs;   // first byte value of the expected field
      logic [6:0] e_sz;
      logic       e_err;
   } vec_t;

   vec_t vecs[$];

   // Bytes start, start+1, ... in the top n byte lanes, zeros below.
   function automatic logic [511:0] mk_bytes(int start, int n);
      logic [511:0] r;
      r = '0;
      for (int i = 0; i < 64; i++) begin
         if (i < n) r[511 - 8*i -: 8] = 8'((start + i) & 255);
      end
      return r;
   endfunction

   function automatic vec_t mk(logic fl, logic iv, int ib, logic rv, logic [6:0] rs, logic ordy,
                               logic e_inr, logic e_rqr, int e_av, logic e_ov, int e_fs,
                               logic [6:0] e_sz, logic e_err);
      vec_t t;
      t.fl = fl; t.iv = iv; t.ib = ib; t.rv = rv; t.rs = rs; t.ordy = ordy;
      t.e_inr = e_inr; t.e_rqr = e_rqr; t.e_av = e_av; t.e_ov = e_ov;
      t.e_fs = e_fs; t.e_sz = e_sz; t.e_err = e_err;
      return t;
   endfunction

   task automatic chk(string name, logic [511:0] act, logic [511:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge.
   task automatic drive(logic fl, logic iv, int ib, logic rv, logic [6:0] rs, logic ordy);
      @(negedge clock);
      flush     = fl;
      in_valid  = iv;
      in_data   = iv ? mk_bytes(ib, 64) : '0;
      req_valid = rv;
      req_size  = rs;
      out_ready = ordy;
      #1;
   endtask

   initial begin
      // Basic beats / extractions
      vecs.push_back(mk(0,1,  0,0, 0,1, 1,0, 64,0,  0, 0,0));
      vecs.push_back(mk(0,0,  0,1,10,1, 1,1, 54,1,  0,10,0));
      vecs.push_back(mk(0,0,  0,1,20,1, 1,1, 34,1, 10,20,0));
      vecs.push_back(mk(0,0,  0,1,34,1, 1,1,  0,1, 30,34,0));
      vecs.push_back(mk(0,0,  0,0, 0,1, 1,0,  0,0,  0, 0,0));
      // Field spanning the beat boundary
      vecs.push_back(mk(0,1,  0,0, 0,1, 1,0, 64,0,  0, 0,0));
      vecs.push_back(mk(0,1, 64,0, 0,1, 1,0,128,0,  0, 0,0));
      vecs.push_back(mk(0,0,  0,1,40,1, 0,1, 88,1,  0,40,0));
      vecs.push_back(mk(0,0,  0,1,40,1, 0,1, 48,1, 40,40,0));
      vecs.push_back(mk(0,0,  0,1,48,1, 1,1,  0,1, 80,48,0));
      // Simultaneous beat and extraction at avail 30
      vecs.push_back(mk(0,1,  0,0, 0,1, 1,0, 64,0,  0, 0,0));
      vecs.push_back(mk(0,0,  0,1,34,1, 1,1, 30,1,  0,34,0));
      vecs.push_back(mk(0,1,100,1,30,1, 1,1, 64,1, 34,30,0));
      vecs.push_back(mk(0,0,  0,1,64,1, 1,1,  0,1,100,64,0));
      vecs.push_back(mk(0,0,  0,0, 0,1, 1,0,  0,0,  0, 0,0));
      // Illegal sizes
      vecs.push_back(mk(0,1,  0,0, 0,1, 1,0, 64,0,  0, 0,0));
      vecs.push_back(mk(0,0,  0,1, 0,1, 1,1, 64,0,  0, 0,1));
      vecs.push_back(mk(0,0,  0,1,65,1, 1,1, 64,0,  0, 0,1));
      // Reach 100 bytes, then flush with a concurrent beat and request
      vecs.push_back(mk(0,1, 64,1,28,1, 1,1,100,1,  0,28,1));
      vecs.push_back(mk(1,1,200,1,10,1, 0,0,  0,0,  0, 0,1));
      vecs.push_back(mk(0,0,  0,0, 0,1, 1,0,  0,0,  0, 0,1));

      resetn = 1'b0; flush = 0; in_valid = 0; in_data = '0;
      req_valid = 0; req_size = 0; out_ready = 0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      resetn = 1'b1;
      #1;
      chk("rst_avail",    avail_bytes, 0);
      chk("rst_out_valid", out_valid,  0);
      chk("rst_out_data",  out_data,   0);
      chk("rst_out_size",  out_size,   0);
      chk("rst_size_err",  size_err,   0);
      req_valid = 1; req_size = 1;
      #1;
      chk("rst_in_ready",  in_ready,  1);
      chk("rst_req_ready", req_ready, 0);

      foreach (vecs[k]) begin
         drive(vecs[k].fl, vecs[k].iv, vecs[k].ib, vecs[k].rv, vecs[k].rs, vecs[k].ordy);
         chk($sformatf("v%0d_in_ready", k),  in_ready,  vecs[k].e_inr);
         chk($sformatf("v%0d_req_ready", k), req_ready, vecs[k].e_rqr);
         @(posedge clock);
         #1;
         chk($sformatf("v%0d_avail", k),     avail_bytes, vecs[k].e_av);
         chk($sformatf("v%0d_out_valid", k), out_valid,   vecs[k].e_ov);
         chk($sformatf("v%0d_size_err", k),  size_err,    vecs[k].e_err);
         if (vecs[k].e_ov) begin
            chk($sformatf("v%0d_out_size", k), out_size, vecs[k].e_sz);
            chk($sformatf("v%0d_out_data", k), out_data, mk_bytes(vecs[k].e_fs, int'(vecs[k].e_sz)));
         end
      end

      // Output backpressure: field 0..7 held while out_ready stays low
      drive(0,1,0,0,0,0);
      @(posedge clock);
      drive(0,0,0,1,8,0);
      chk("bp_first_req_ready", req_ready, 1);
      @(posedge clock);
      for (int c = 0; c < 5; c++) begin
         drive(0,0,0,1,8,0);
         chk($sformatf("bp%0d_req_ready", c), req_ready, 0);
         @(posedge clock);
         #1;
         chk($sformatf("bp%0d_out_data", c), out_data, mk_bytes(0, 8));
         chk($sformatf("bp%0d_avail", c),    avail_bytes, 56);
         chk($sformatf("bp%0d_out_valid", c), out_valid, 1);
      end
      drive(0,0,0,1,8,1);
      chk("bp_release_req_ready", req_ready, 1);
      @(posedge clock);
      #1;
      chk("bp_release_out_data", out_data, mk_bytes(8, 8));
      chk("bp_release_avail",    avail_bytes, 48);

      // Flush leaves the output register and size_err alone
      drive(1,0,0,0,0,0);
      @(posedge clock);
      #1;
      chk("fl_avail",     avail_bytes, 0);
      chk("fl_out_valid", out_valid, 1);
      chk("fl_out_data",  out_data, mk_bytes(8, 8));
      chk("fl_out_size",  out_size, 8);
      chk("fl_size_err",  size_err, 1);

      // Reset while a field is pending and a beat/request is offered
      drive(0,1,0,1,4,0);
      resetn = 1'b0;
      @(posedge clock);
      #1;
      resetn = 1'b1;
      chk("mid_rst_avail",     avail_bytes, 0);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_out_data",  out_data, 0);
      chk("mid_rst_out_size",  out_size, 0);
      chk("mid_rst_size_err",  size_err, 0);
      drive(0,0,0,1,1,1);
      chk("mid_rst_in_ready",  in_ready, 1);
      chk("mid_rst_req_ready", req_ready, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
